// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit with architectural HI/LO registers.
// Iterates WIDTH/BITS_PER_CYCLE steps: shift-add multiply, restoring divide.
// Optional macro SIGNED_MULDIV_EN: MULT/DIV (op[1]=1) use two's-complement
// operands; when undefined, op[1] is ignored and MULT/DIV behave as MULTU/DIVU.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, busy=1 for WIDTH/BITS_PER_CYCLE cycles
// DONE  | done=1 for one cycle, hi/lo/div_by_zero hold the new result

module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               b_zero;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] work;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] work_nxt;
    logic [WIDTH+BPC-1:0] mul_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem, quo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

`ifndef SIGNED_MULDIV_EN
    logic unused_op_sign;
    assign unused_op_sign = op[1];
`endif

    // Operand conditioning at start: signed ops are reduced to magnitudes.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
`ifdef SIGNED_MULDIV_EN
        if (op[1]) begin
            a_neg = a[WIDTH-1];
            b_neg = b[WIDTH-1];
        end
`endif
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration step: BPC multiplier bits added in, or BPC quotient bits produced.
    always_comb begin
        mul_sum = {{BPC{1'b0}}, work[2*WIDTH-1:WIDTH]}
                + ((WIDTH+BPC)'(mcand) * (WIDTH+BPC)'(work[BPC-1:0]));
        rem   = work[2*WIDTH-1:WIDTH];
        quo   = work[WIDTH-1:0];
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {rem, quo[WIDTH-1]};
            quo   = {quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, mcand}) begin
                trial  = trial - {1'b0, mcand};
                quo[0] = 1'b1;
            end
            rem = trial[WIDTH-1:0];
        end
        if (is_div) work_nxt = {rem, quo};
        else        work_nxt = {mul_sum, work[WIDTH-1:BPC]};
    end

    // Final result from the last step, with sign fix-up and divide-by-zero override.
    always_comb begin
        prod_fix = neg_q ? -work_nxt : work_nxt;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            res_lo = neg_q ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
            res_hi = neg_r ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];
            if (b_zero) begin
                res_lo = '1;
                res_hi = a_orig;
            end
        end
    end

    // Control FSM and datapath registers; hi/lo only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            count       <= '0;
            is_div      <= 1'b0;
            b_zero      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            a_orig      <= '0;
            mcand       <= '0;
            work        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                CALC: begin
                    work  <= work_nxt;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        hi          <= res_hi;
                        lo          <= res_lo;
                        div_by_zero <= b_zero;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        count  <= CW'(STEPS);
                        is_div <= op[0];
                        b_zero <= op[0] & (b == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg & op[0];
                        a_orig <= a;
                        if (op[0]) begin
                            mcand <= b_mag;
                            work  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            mcand <= a_mag;
                            work  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, BPC=1 and BPC=4 instances).
// Signed checks follow SIGNED_MULDIV_EN when it is defined for the build.

module tb_muldiv_unit;

    localparam int W = 32;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, dbz, busy4, done4, dbz4;
    logic [W-1:0] hi, lo, hi4, lo4;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad = 0;

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo));

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4));

    always #5 clk = ~clk;

    function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        logic [2*W-1:0] p;
        logic sgn;
        int sx, sy;
`ifdef SIGNED_MULDIV_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        r = '0;
        if (!o[0]) begin
            if (sgn) p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
            else     p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            r.hi = p[2*W-1:W];
            r.lo = p[W-1:0];
        end else if (y == '0) begin
            r.lo = '1;
            r.hi = x;
            r.dbz = 1'b1;
        end else if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                r.lo = 32'h8000_0000;
                r.hi = '0;
            end else begin
                sx = x;
                sy = y;
                r.lo = sx / sy;
                r.hi = sx % sy;
            end
        end else begin
            r.lo = x / y;
            r.hi = x % y;
        end
        return r;
    endfunction

    // Called ~1 time unit after an edge; start is sampled at the next edge,
    // after which operands are scrambled to prove they were latched.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // cyc = further edges until done is seen high (latency = cyc + 1 edges).
    task automatic wait_done(output int cyc, output int busy_cnt, output bit ok);
        cyc = 0; ok = 1'b0;
        busy_cnt = busy ? 1 : 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin ok = 1'b1; break; end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, dbz, hi, lo} !== '0) begin bad++;
            $display("FAIL reset_state got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy, done, dbz, hi, lo); end
        total++;
        if ({busy4, done4, dbz4, hi4, lo4} !== '0) begin bad++;
            $display("FAIL reset_state4 got busy=%b done=%b hi=%h lo=%h want all 0", busy4, done4, hi4, lo4); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00) begin bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_multu();
        int cyc, bc; bit ok; res_t e;
        sb.push_back(model(2'b00, 32'hFFFF_FFFF, 32'd2));
        issue(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done(cyc, bc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL multu_timeout got no done want done"); end
        total++;
        if (cyc + 1 !== N + 1) begin bad++; $display("FAIL multu_latency got %0d want %0d", cyc + 1, N + 1); end
        total++;
        if (bc !== N) begin bad++; $display("FAIL multu_busy_cycles got %0d want %0d", bc, N); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_in_done got %b want 0", busy); end
        e = sb.pop_front();
        total++;
        if ({hi, lo, dbz} !== e) begin bad++; $display("FAIL multu_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b", hi, lo, dbz, e.hi, e.lo, e.dbz); end
        total++;
        if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin bad++; $display("FAIL multu_const got %h%h want 00000001fffffffe", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; bit ok; res_t e;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(model(2'b01, 32'd100, 32'd7));
        issue(2'b01, 32'd100, 32'd7);
        wait_done(cyc, bc, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {hi, lo, dbz} !== e || lo !== 32'd14 || hi !== 32'd2) begin bad++;
            $display("FAIL divu_result got ok=%b hi=%0d lo=%0d dbz=%b want hi=2 lo=14 dbz=0", ok, hi, lo, dbz); end
        sb.push_back(model(2'b01, 32'd100, 32'd7));
        issue(2'b01, 32'd100, 32'd7);
        total++;
        if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_no_gap got busy=%b done=%b want 1 0", busy, done); end
        wait_done(cyc, bc, ok);
        total++;
        if (!ok || cyc + 1 !== N + 1) begin bad++; $display("FAIL b2b_latency got ok=%b cycles=%0d want %0d", ok, cyc + 1, N + 1); end
        e = sb.pop_front();
        total++;
        if ({hi, lo, dbz} !== e) begin bad++; $display("FAIL b2b_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h", hi, lo, dbz, e.hi, e.lo); end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got %b want 0", done); end
    endtask

    task automatic test_div_by_zero();
        int cyc, bc; bit ok; res_t e;
        sb.push_back(model(2'b01, 32'd5, 32'd0));
        issue(2'b01, 32'd5, 32'd0);
        wait_done(cyc, bc, ok);
        e = sb.pop_front();
        total++;
        if (!ok || cyc !== N || {hi, lo, dbz} !== e || {hi, lo, dbz} !== {32'd5, 32'hFFFF_FFFF, 1'b1}) begin bad++;
            $display("FAIL dbz_result got ok=%b cyc=%0d hi=%h lo=%h dbz=%b want hi=5 lo=ffffffff dbz=1", ok, cyc, hi, lo, dbz); end
        sb.push_back(model(2'b00, 32'd3, 32'd4));
        issue(2'b00, 32'd3, 32'd4);
        wait_done(cyc, bc, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {hi, lo, dbz} !== e || {hi, lo, dbz} !== {32'd0, 32'd12, 1'b0}) begin bad++;
            $display("FAIL dbz_clear got ok=%b hi=%h lo=%h dbz=%b want hi=0 lo=12 dbz=0", ok, hi, lo, dbz); end
    endtask

    task automatic test_start_ignored();
        int ndone; res_t e;
        repeat (2) @(posedge clk);
        #1;
        ndone = 0;
        sb.push_back(model(2'b00, 32'd123456, 32'd789));
        issue(2'b00, 32'd123456, 32'd789);
        for (int c = 1; c < N + 10; c++) begin
            if (c % 5 == 2 && c < N - 2) begin
                start = 1'b1; op = 2'b01; a = $urandom; b = $urandom_range(1, 100);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    e = sb.pop_front();
                    total++;
                    if ({hi, lo, dbz} !== e) begin bad++;
                        $display("FAIL ignore_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo); end
                end
            end
        end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        issue(2'b00, 32'hDEAD_BEEF, 32'h1234);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, dbz, hi, lo} !== '0) begin bad++;
            $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
        reset = 1'b0;
        for (int c = 0; c < N + 10; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        total++;
        if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got %0d dones want 0", ndone); end
    endtask

    task automatic test_signed();
        logic [1:0]   t_op [3] = '{2'b10, 2'b11, 2'b11};
        logic [W-1:0] t_a  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [W-1:0] t_b  [3] = '{32'd5, 32'd2, 32'hFFFF_FFFF};
`ifdef SIGNED_MULDIV_EN
        logic [2*W-1:0] t_hl [3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000};
`else
        logic [2*W-1:0] t_hl [3] = '{64'h0000_0004_FFFF_FFF1, 64'h0000_0001_7FFF_FFFC, 64'h8000_0000_0000_0000};
`endif
        int cyc, bc; bit ok; res_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(model(t_op[i], t_a[i], t_b[i]));
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(cyc, bc, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {hi, lo, dbz} !== e || {hi, lo} !== t_hl[i] || cyc !== N) begin bad++;
                $display("FAIL signed_%0d got ok=%b cyc=%0d hi=%h lo=%h dbz=%b want hi:lo=%h", i, ok, cyc, hi, lo, dbz, t_hl[i]); end
        end
    endtask

    task automatic test_bpc4();
        logic [1:0]   t_op [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [W-1:0] t_a  [6] = '{32'hFFFF_FFFF, 32'd100, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [W-1:0] t_b  [6] = '{32'd2, 32'd7, 32'd0, 32'd5, 32'd2, 32'hFFFF_FFFF};
        int cyc, bc, cyc4; bit ok, ok4; res_t e;
        for (int i = 0; i < 6; i++) begin
            repeat (2) @(posedge clk);
            #1;
            sb.push_back(model(t_op[i], t_a[i], t_b[i]));
            issue(t_op[i], t_a[i], t_b[i]);
            cyc4 = 0; ok4 = 1'b0;
            while (cyc4 < 50) begin
                @(posedge clk); #1;
                cyc4++;
                if (done4) begin ok4 = 1'b1; break; end
            end
            e = sb[0];
            total++;
            if (!ok4 || cyc4 + 1 !== 9 || {hi4, lo4, dbz4} !== e) begin bad++;
                $display("FAIL bpc4_%0d got ok=%b latency=%0d hi=%h lo=%h dbz=%b want 9 hi=%h lo=%h dbz=%b",
                         i, ok4, cyc4 + 1, hi4, lo4, dbz4, e.hi, e.lo, e.dbz); end
            wait_done(cyc, bc, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {hi, lo, dbz} !== e) begin bad++;
                $display("FAIL bpc1_pair_%0d got ok=%b hi=%h lo=%h want hi=%h lo=%h", i, ok, hi, lo, e.hi, e.lo); end
        end
    endtask

    task automatic test_random();
        int cyc, bc; bit ok; res_t e;
        logic [1:0] o; logic [W-1:0] x, y;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case (i % 3)
                0: y = $urandom;
                1: y = $urandom_range(1, 1000);
                default: y = (i == 5) ? 32'd0 : 32'($urandom_range(0, 15)) - 32'd8;
            endcase
            sb.push_back(model(o, x, y));
            issue(o, x, y);
            wait_done(cyc, bc, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {hi, lo, dbz} !== e) begin bad++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                         i, o, x, y, hi, lo, dbz, e.hi, e.lo, e.dbz); end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_back_to_back();
        test_div_by_zero();
        test_start_ignored();
        test_reset_abort();
        test_signed();
        test_bpc4();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
